// File: rtl/wb_queue.sv
// ---------------------------------------------------------------------------
// wb_queue -- register-file writeback queue
//
// This block merges load-unit and ALU results into one FIFO. It drains the
// FIFO into a single registered register-file write port. Load results take
// priority over ALU results, so at most one result is accepted per cycle.
// Results for r0 complete their handshake but are dropped. Two hazard-check
// ports report whether a register write is still pending for an operand
// address. A write is pending while it sits in the FIFO or is being
// presented on the write port.
//
// Ports
//   elk                  : clock, all state updates on the rising edge
//   nrst                 : asynchronous reset, active-high
//   mem_valid/addr/data  : load-unit result (valid/ready handshake)
//   mem_ready            : queue accepts the load result this cycle
//   alu_valid/addr/data  : ALU result (valid/ready handshake)
//   alu_ready            : queue accepts the ALU result this cycle
//   wb_hold              : register-file write port unavailable, stall drain
//   wr_en/wr_addr/wr_data: registered register-file write port
//   chk_addrA/chk_addrB  : operand addresses being read this cycle
//   pendA/pendB          : a write to that operand address is still in flight
//   count                : registered FIFO occupancy
// ---------------------------------------------------------------------------
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       elk,
    input  logic                       nrst,
    input  logic                       mem_valid,
    input  logic [4:0]                 mem_addr,
    input  logic [31:0]                mem_data,
    output logic                       mem_ready,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_addr,
    input  logic [31:0]                alu_data,
    output logic                       alu_ready,
    input  logic                       wb_hold,
    output logic                       wr_en,
    output logic [4:0]                 wr_addr,
    output logic [31:0]                wr_data,
    input  logic [4:0]                 chk_addrA,
    input  logic [4:0]                 chk_addrB,
    output logic                       pendA,
    output logic                       pendB,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;

    logic [4:0]    q_addr [DEPTH];
    logic [31:0]   q_data [DEPTH];
    ptr_t          head;
    ptr_t          tail;
    logic [CW-1:0] occ;

    logic          full;
    logic          empty;
    logic          in_fire;
    logic [4:0]    in_addr;
    logic [31:0]   in_data;
    logic          push;
    logic          pop;
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] hit_a;
    logic [DEPTH-1:0] hit_b;

    // Full and empty come from the occupancy at the start of the cycle.
    // A pop on this edge therefore never opens a slot for this cycle's push.
    assign full      = (occ == CW'(DEPTH));
    assign empty     = (occ == '0);
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;

    assign in_fire = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    assign in_addr = mem_valid ? mem_addr : alu_addr;
    assign in_data = mem_valid ? mem_data : alu_data;
    assign push    = in_fire && (in_addr != 5'd0);
    assign pop     = !wb_hold && !empty;
    assign count   = occ;

    // An entry is live when its distance from head is below the occupancy.
    // The pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        live  = '0;
        hit_a = '0;
        hit_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live[i]  = ({1'b0, ptr_t'(i) - head} < occ);
            hit_a[i] = live[i] && (q_addr[i] == chk_addrA);
            hit_b[i] = live[i] && (q_addr[i] == chk_addrB);
        end
    end

    assign pendA = (chk_addrA != 5'd0) &&
                   ((|hit_a) || (wr_en && (wr_addr == chk_addrA)));
    assign pendB = (chk_addrB != 5'd0) &&
                   ((|hit_b) || (wr_en && (wr_addr == chk_addrB)));

    // Control state and the write port.
    always_ff @(posedge elk or posedge nrst) begin
        if (nrst) begin
            head    <= '0;
            tail    <= '0;
            occ     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;

            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase

            if (pop) begin
                wr_en   <= 1'b1;
                wr_addr <= q_addr[head];
                wr_data <= q_data[head];
            end else begin
                wr_en   <= 1'b0;
            end
        end
    end

    // NOTE: the entry storage is not reset; occupancy alone defines which entries are valid.
    always_ff @(posedge elk) begin
        if (push) begin
            q_addr[tail] <= in_addr;
            q_data[tail] <= in_data;
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// ---------------------------------------------------------------------------
// tb_wb_queue -- directed checks for wb_queue (DEPTH = 4)
//
// A table of vectors covers single writes, priority, r0 drop and hazard
// reporting. Hand-written sequences cover the multi-cycle cases: filling
// while held, reset during operation, and pointer wrap.
// ---------------------------------------------------------------------------
module tb_wb_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          elk = 1'b0;
    logic          nrst;
    logic          mem_valid, alu_valid, wb_hold;
    logic [4:0]    mem_addr, alu_addr, chk_addrA, chk_addrB;
    logic [31:0]   mem_data, alu_data;
    logic          mem_ready, alu_ready, wr_en, pendA, pendB;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_passed = 0;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .elk       (elk),
        .nrst      (nrst),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .wb_hold   (wb_hold),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .chk_addrA (chk_addrA),
        .chk_addrB (chk_addrB),
        .pendA     (pendA),
        .pendB     (pendB),
        .count     (count)
    );

    always #5 elk = ~elk;

    typedef struct {
        logic        mv;  logic [4:0] ma;  logic [31:0] md;
        logic        av;  logic [4:0] aa;  logic [31:0] ad;
        logic        hold; logic [4:0] ca; logic [4:0] cb;
        logic        e_mr; logic e_ar; logic e_we;
        logic [4:0]  e_wa; logic [31:0] e_wd; int e_cnt;
        logic        e_pa; logic e_pb;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        mem_valid = 0; mem_addr = 0; mem_data = 0;
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        wb_hold = 0; chk_addrA = 0; chk_addrB = 0;
    endtask

    // Called just after a rising edge: drive, settle, compare, advance one edge.
    task automatic apply_vec(input int idx, input vec_t v);
        string tag;
        mem_valid = v.mv; mem_addr = v.ma; mem_data = v.md;
        alu_valid = v.av; alu_addr = v.aa; alu_data = v.ad;
        wb_hold = v.hold; chk_addrA = v.ca; chk_addrB = v.cb;
        #1;
        tag = $sformatf("vec%0d", idx);
        check({tag, ".mem_ready"}, 32'(mem_ready), 32'(v.e_mr));
        check({tag, ".alu_ready"}, 32'(alu_ready), 32'(v.e_ar));
        check({tag, ".wr_en"},     32'(wr_en),     32'(v.e_we));
        check({tag, ".wr_addr"},   32'(wr_addr),   32'(v.e_wa));
        check({tag, ".wr_data"},   wr_data,        v.e_wd);
        check({tag, ".count"},     32'(count),     32'(v.e_cnt));
        check({tag, ".pendA"},     32'(pendA),     32'(v.e_pa));
        check({tag, ".pendB"},     32'(pendB),     32'(v.e_pb));
        @(posedge elk); #1;
    endtask

    initial begin
        logic [4:0]  exp_a [9];
        logic [31:0] exp_d [9];

        //          mv ma  md            av aa  ad            hd ca cb  mr ar we wa  wd            cnt pa pb
        vecs[0]  = '{0, 0,  0,            0, 0,  0,            0, 0, 0,  1, 1, 0, 0,  0,            0,  0, 0};
        vecs[1]  = '{0, 0,  0,            1, 5,  32'hDEADBEEF, 0, 5, 0,  1, 1, 0, 0,  0,            0,  0, 0};
        vecs[2]  = '{0, 0,  0,            0, 0,  0,            0, 5, 0,  1, 1, 0, 0,  0,            1,  1, 0};
        vecs[3]  = '{0, 0,  0,            0, 0,  0,            0, 5, 0,  1, 1, 1, 5,  32'hDEADBEEF, 0,  1, 0};
        vecs[4]  = '{0, 0,  0,            0, 0,  0,            0, 5, 0,  1, 1, 0, 5,  32'hDEADBEEF, 0,  0, 0};
        vecs[5]  = '{1, 3,  32'h33,       1, 4,  32'h44,       0, 0, 0,  1, 0, 0, 5,  32'hDEADBEEF, 0,  0, 0};
        vecs[6]  = '{0, 0,  0,            1, 4,  32'h44,       0, 3, 4,  1, 1, 0, 5,  32'hDEADBEEF, 1,  1, 0};
        vecs[7]  = '{0, 0,  0,            0, 0,  0,            0, 3, 4,  1, 1, 1, 3,  32'h33,       1,  1, 1};
        vecs[8]  = '{0, 0,  0,            0, 0,  0,            0, 3, 4,  1, 1, 1, 4,  32'h44,       0,  0, 1};
        vecs[9]  = '{0, 0,  0,            0, 0,  0,            0, 3, 4,  1, 1, 0, 4,  32'h44,       0,  0, 0};
        vecs[10] = '{0, 0,  0,            1, 0,  32'h1234,     0, 0, 0,  1, 1, 0, 4,  32'h44,       0,  0, 0};
        vecs[11] = '{0, 0,  0,            0, 0,  0,            0, 0, 0,  1, 1, 0, 4,  32'h44,       0,  0, 0};
        vecs[12] = '{0, 0,  0,            0, 0,  0,            0, 0, 0,  1, 1, 0, 4,  32'h44,       0,  0, 0};
        vecs[13] = '{1, 7,  32'h77,       0, 0,  0,            1, 7, 8,  1, 0, 0, 4,  32'h44,       0,  0, 0};
        vecs[14] = '{0, 0,  0,            0, 0,  0,            1, 7, 8,  1, 1, 0, 4,  32'h44,       1,  1, 0};
        vecs[15] = '{0, 0,  0,            0, 0,  0,            0, 7, 8,  1, 1, 0, 4,  32'h44,       1,  1, 0};
        vecs[16] = '{0, 0,  0,            0, 0,  0,            0, 7, 8,  1, 1, 1, 7,  32'h77,       0,  1, 0};
        vecs[17] = '{0, 0,  0,            0, 0,  0,            0, 7, 8,  1, 1, 0, 7,  32'h77,       0,  0, 0};

        // Reset, checked while still asserted.
        idle_inputs();
        nrst = 1;
        repeat (2) @(posedge elk);
        #1;
        check("rst.wr_en",   32'(wr_en),   0);
        check("rst.count",   32'(count),   0);
        check("rst.wr_addr", 32'(wr_addr), 0);
        check("rst.wr_data", wr_data,      0);
        nrst = 0;
        @(posedge elk); #1;

        for (int i = 0; i < 18; i++) apply_vec(i, vecs[i]);

        // Fill while held; the queue refuses a fifth entry.
        idle_inputs();
        wb_hold = 1;
        for (int i = 0; i < DEPTH; i++) begin
            mem_valid = 1; mem_addr = 5'(10 + i); mem_data = 32'h100 + i;
            #1;
            check($sformatf("fill%0d.mem_ready", i), 32'(mem_ready), 1);
            @(posedge elk); #1;
        end
        mem_addr = 20; mem_data = 32'hBAD;
        alu_valid = 1; alu_addr = 21; alu_data = 32'hBAD;
        #1;
        check("full.count",     32'(count),     DEPTH);
        check("full.mem_ready", 32'(mem_ready), 0);
        check("full.alu_ready", 32'(alu_ready), 0);
        @(posedge elk); #1;
        check("full_hold.count", 32'(count), DEPTH);
        // Releasing the hold pops this edge, yet ready stays low while full.
        wb_hold = 0;
        #1;
        check("full_pop.mem_ready", 32'(mem_ready), 0);
        @(posedge elk); #1;
        mem_valid = 0; alu_valid = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i > 0) begin
                @(posedge elk); #1;
            end
            check($sformatf("drain%0d.wr_en", i),   32'(wr_en),   1);
            check($sformatf("drain%0d.wr_addr", i), 32'(wr_addr), 10 + i);
            check($sformatf("drain%0d.wr_data", i), wr_data,      32'h100 + i);
        end
        @(posedge elk); #1;
        check("drained.wr_en", 32'(wr_en), 0);
        check("drained.count", 32'(count), 0);

        // Reset with three entries queued and a write on the port.
        wb_hold = 1;
        for (int i = 0; i < DEPTH; i++) begin
            mem_valid = 1; mem_addr = 5'(1 + i); mem_data = 32'hA0 + i;
            @(posedge elk); #1;
        end
        mem_valid = 0;
        wb_hold = 0;
        @(posedge elk); #1;
        check("pre_rst.wr_en", 32'(wr_en), 1);
        check("pre_rst.count", 32'(count), 3);
        wb_hold = 1;
        chk_addrA = 2;
        #1;
        check("pre_rst.pendA", 32'(pendA), 1);
        nrst = 1;
        #1;
        check("mid_rst.wr_en",     32'(wr_en),     0);
        check("mid_rst.count",     32'(count),     0);
        check("mid_rst.mem_ready", 32'(mem_ready), 1);
        check("mid_rst.pendA",     32'(pendA),     0);
        @(posedge elk); #1;
        nrst = 0;
        wb_hold = 0;
        @(posedge elk); #1;
        check("post_rst.wr_en", 32'(wr_en), 0);
        check("post_rst.count", 32'(count), 0);

        // 2*DEPTH+1 back-to-back pushes; each appears on the port one edge later.
        chk_addrA = 0;
        for (int j = 0; j <= 2 * DEPTH + 1; j++) begin
            if (j < 2 * DEPTH + 1) begin
                exp_a[j] = 5'(j % 31 + 1);
                exp_d[j] = 32'hC000 + 32'(j * 7);
                alu_valid = 1; alu_addr = exp_a[j]; alu_data = exp_d[j];
                #1;
                check($sformatf("wrap%0d.alu_ready", j), 32'(alu_ready), 1);
            end else begin
                alu_valid = 0;
            end
            @(posedge elk); #1;
            if (j >= 1) begin
                check($sformatf("wrap%0d.wr_en", j),   32'(wr_en),   1);
                check($sformatf("wrap%0d.wr_addr", j), 32'(wr_addr), 32'(exp_a[j-1]));
                check($sformatf("wrap%0d.wr_data", j), wr_data,      exp_d[j-1]);
            end
            check($sformatf("wrap%0d.count", j), 32'(count), (j < 2 * DEPTH + 1) ? 1 : 0);
        end
        @(posedge elk); #1;
        check("wrap_end.wr_en", 32'(wr_en), 0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered writeback entries (power of 2, 2..16).
REQ-002 SHALL have port elk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port nrst  input  1  reset, asynchronous, active-high (1 = reset asserted).
REQ-004 SHALL have port mem_valid  input  1  load-unit result valid.
REQ-005 SHALL have port mem_addr  input  5  load destination register.
REQ-006 SHALL have port mem_data  input  32  load result.
REQ-007 SHALL have port mem_ready  output  1  queue accepts load result this cycle.
REQ-008 SHALL have port alu_valid  input  1  ALU result valid.
REQ-009 SHALL have port alu_addr  input  5  ALU destination register.
REQ-010 SHALL have port alu_data  input  32  ALU result.
REQ-011 SHALL have port alu_ready  output  1  queue accepts ALU result this cycle.
REQ-012 SHALL have port wb_hold  input  1  register-file write port unavailable; stall drain.
REQ-013 SHALL have port wr_en  output  1  register-file write enable (registered).
REQ-014 SHALL have port wr_addr  output  5  register-file write address (registered).
REQ-015 SHALL have port wr_data  output  32  register-file write data (registered).
REQ-016 SHALL have ports chk_addrA, chk_addrB  input  5 each  operand addresses being read this cycle.
REQ-017 SHALL have ports pendA, pendB  output  1 each  write to that operand address still in flight.
REQ-018 SHALL have port count  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-019 SHALL accept at most one result per cycle; handshake completes when valid && ready at a rising edge.
REQ-020 SHALL drive mem_ready = !full; alu_ready = !full && !mem_valid (load has priority).
REQ-021 SHALL compute full from occupancy at cycle start; a same-cycle pop SHALL NOT raise ready while full.
REQ-022 SHALL, on accepted result with addr 0, complete the handshake but not enqueue it (r0 writes dropped).
REQ-023 SHALL, on accepted result with addr != 0, write {addr, data} at the tail and advance tail (mod DEPTH).
REQ-024 SHALL, each edge with wb_hold=0 and FIFO non-empty, pop the head into wr_addr/wr_data and set wr_en=1.
REQ-025 SHALL, each edge with wb_hold=1 or FIFO empty, set wr_en=0 and hold wr_addr/wr_data.
REQ-026 SHALL give latency of 2 edges: accepted at edge k into empty queue -> wr_en=1 during cycle after edge k+1.
REQ-027 SHALL support push and pop on the same edge; count unchanged, order preserved (strict FIFO).
REQ-028 SHALL wrap head and tail pointers modulo DEPTH without loss or duplication.
REQ-029 SHALL never pop when empty and never push when full; count in 0..DEPTH at all times.
REQ-030 SHALL drive pendA=1 iff chk_addrA != 0 and matches any valid FIFO entry or (wr_en && wr_addr); same for pendB.
REQ-031 SHALL compute pendA/pendB combinationally from current state; same-cycle inbound handshake SHALL NOT affect them.
REQ-032 SHALL drive count from registered occupancy.

Reset
REQ-033 SHALL, while nrst=1, immediately force wr_en=0, wr_addr=0, wr_data=0, count=0, head=tail=0, all entries invalid.
REQ-034 SHALL discard all queued results on reset mid-operation; no wr_en pulse in the cycle after release.
REQ-035 SHALL drive mem_ready=1, alu_ready=!mem_valid, pendA=pendB=0 after reset.

Verification
REQ-036 Single ALU write addr 5 data 0xDEADBEEF into empty queue -> wr_en=1, wr_addr=5, wr_data=0xDEADBEEF 2 edges later, one cycle only.
REQ-037 mem_valid and alu_valid both high (addr 3, addr 4) -> mem accepted, alu_ready=0; alu accepted next cycle; writes reach port as 3 then 4.
REQ-038 wb_hold=1 while pushing DEPTH entries -> count=DEPTH, mem_ready=0; release hold -> DEPTH consecutive wr_en pulses in push order, then count=0.
REQ-039 Write addr 0 data 0x1234 -> handshake completes, count stays 0, no wr_en pulse, pendA=0 for chk_addrA=0.
REQ-040 Push addr 7 with wb_hold=1, chk_addrA=7 -> pendA=1 until cycle after the wr_en pulse for addr 7; pendB=0 for chk_addrB=8.
REQ-041 Assert nrst with 3 entries queued and wr_en=1 -> wr_en=0, count=0 immediately; after release no writes emitted; pointers wrap correctly over 2*DEPTH+1 subsequent pushes.
